// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the counter family: FSM state encoding and the
//   default sizing constants used by modulo_up_counter and tick_prescaler.
//   No ports.

package counter_pkg;

   // Encoding 2'd3 is unused; the counter FSM recovers from it to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned CNT_N_DEFAULT      = 3;
   localparam int unsigned PRESCALE_W_DEFAULT = 8;

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Divides the clock into a tick strobe: one tick every div+1 clocks.
//   div = 0 ticks on every clock. clear restarts the phase from zero.
// Ports
//   clock  in   clock, all state on posedge
//   reset  in   asynchronous active-high reset
//   clear  in   synchronous phase clear; suppresses tick while high
//   div    in   [PRESCALE_W-1:0] divisor minus one
//   tick   out  strobe, high on the last clock of each div+1 period

module tick_prescaler
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE_W = PRESCALE_W_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] div,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic                  at_end;

   assign at_end = (cnt_q == div);
   assign tick   = at_end && !clear;

   always_comb begin
      cnt_d = cnt_q + PRESCALE_W'(1);
      if (clear || at_end) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : tick_prescaler

// File: rtl/modulo_up_counter.sv
// modulo_up_counter
//   Programmable modulo up counter. Counts 0..limit then wraps to 0
//   (free-running) or halts at limit (one-shot). A 3-state FSM
//   (IDLE/RUN/DONE) handles start/stop; tc is a registered one-cycle
//   terminal-count pulse. All outputs are registered.
//   Optional feature macro: MODULO_UP_COUNTER_PRESCALE_EN adds the presc_div
//   port and a tick_prescaler; otherwise the counter ticks every clock.
// Ports
//   clock      in   clock, all state on posedge
//   reset      in   asynchronous active-high reset
//   start      in   launch from IDLE/DONE (ignored in RUN, loses to stop)
//   stop       in   abort to IDLE, count cleared
//   one_shot   in   sampled at launch: 1 = halt at limit, 0 = wrap
//   limit      in   [N:0] terminal value, sampled at launch
//   presc_div  in   [PRESCALE_W-1:0] tick every presc_div+1 clocks (macro only)
//   count      out  [N:0] current count
//   tc         out  one-cycle terminal-count pulse
//   busy       out  high in RUN
//   done       out  high in DONE

module modulo_up_counter
   import counter_pkg::*;
#(
   parameter int unsigned N          = CNT_N_DEFAULT,
   parameter int unsigned PRESCALE_W = PRESCALE_W_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  one_shot,
   input  logic [N:0]            limit,
`ifdef MODULO_UP_COUNTER_PRESCALE_EN
   input  logic [PRESCALE_W-1:0] presc_div,
`endif
   output logic [N:0]            count,
   output logic                  tc,
   output logic                  busy,
   output logic                  done
);

   state_e     state_q, state_d;
   logic [N:0] count_q, count_d;
   logic [N:0] limit_q, limit_d;
   logic       one_shot_q, one_shot_d;
   logic       tc_q, tc_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       launch;
   logic       tick;

`ifdef MODULO_UP_COUNTER_PRESCALE_EN
   logic [PRESCALE_W-1:0] div_q, div_d;
   logic                  presc_clear;

   // Phase restarts whenever the counter is not running or is being stopped,
   // so every launch begins a full presc_div+1 period.
   assign presc_clear = (state_q != RUN) || stop;
   assign div_d       = launch ? presc_div : div_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   tick_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_tick_prescaler (
      .clock (clock),
      .reset (reset),
      .clear (presc_clear),
      .div   (div_q),
      .tick  (tick)
   );
`else
   logic unused_presc_w;

   assign tick           = 1'b1;
   assign unused_presc_w = (PRESCALE_W != 0);
`endif

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      limit_d    = limit_q;
      one_shot_d = one_shot_q;
      tc_d       = 1'b0;
      launch     = 1'b0;

      case (state_q)
         IDLE: begin
            count_d = '0;
            launch  = start && !stop;
         end
         RUN: begin
            if (stop) begin
               // Any terminal count due this cycle is dropped.
               state_d = IDLE;
               count_d = '0;
            end else if (tick) begin
               if (count_q == limit_q) begin
                  tc_d = 1'b1;
                  if (one_shot_q) begin
                     state_d = DONE;
                  end else begin
                     count_d = '0;
                  end
               end else begin
                  count_d = count_q + (N+1)'(1);
               end
            end
         end
         DONE: begin
            if (stop) begin
               state_d = IDLE;
               count_d = '0;
            end else begin
               launch = start;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase

      if (launch) begin
         state_d    = RUN;
         count_d    = '0;
         limit_d    = limit;
         one_shot_d = one_shot;
      end
   end

   assign busy_d = (state_d == RUN);
   assign done_d = (state_d == DONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         limit_q    <= '0;
         one_shot_q <= 1'b0;
         tc_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         limit_q    <= limit_d;
         one_shot_q <= one_shot_d;
         tc_q       <= tc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule : modulo_up_counter

// File: tb/tb_modulo_up_counter.sv
module tb_modulo_up_counter;

   localparam int unsigned N  = 3;
   localparam int unsigned PW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          one_shot = 1'b0;
   logic [N:0]    limit = '0;
   logic [PW-1:0] presc_div = '0;
   logic [N:0]    count;
   logic          tc;
   logic          busy;
   logic          done;

   modulo_up_counter #(
      .N          (N),
      .PRESCALE_W (PW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .one_shot  (one_shot),
      .limit     (limit),
`ifdef MODULO_UP_COUNTER_PRESCALE_EN
      .presc_div (presc_div),
`endif
      .count     (count),
      .tc        (tc),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: mode 0 idle, 1 running, 2 done.
   typedef struct {
      int cnt;
      bit tc;
      bit busy;
      bit done;
   } exp_t;

   exp_t sb[$];

   int m_mode, m_cnt, m_lim, m_os, m_div, m_ph;
   bit m_tc;

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_lim = 0; m_os = 0; m_div = 0; m_ph = 0; m_tc = 0;
   endtask

   task automatic model_step(input bit st, input bit sp, input bit os, input int lim, input int dv);
      bit tick;
      m_tc = 0;
      if (sp) begin
         m_mode = 0; m_cnt = 0; m_ph = 0;
      end else if (m_mode != 1 && st) begin
         m_mode = 1; m_cnt = 0; m_lim = lim; m_os = os; m_div = dv; m_ph = 0;
      end else if (m_mode == 1) begin
         tick = (m_ph == m_div);
         m_ph = (m_ph + 1) % (m_div + 1);
         if (tick) begin
            if (m_cnt == m_lim) m_tc = 1;
            if (m_cnt == m_lim && m_os != 0) m_mode = 2;
            else m_cnt = (m_cnt + 1) % (m_lim + 1);
         end
      end
   endtask

   // One clock of stimulus: drive on the falling edge, queue what the
   // outputs must show after the following rising edge.
   task automatic cycle(input bit st, input bit sp, input bit os, input int lim, input int dv);
      exp_t e;
      int   mdv;
      @(negedge clock);
      start     = st;
      stop      = sp;
      one_shot  = os;
      limit     = lim[N:0];
      presc_div = dv[PW-1:0];
`ifdef MODULO_UP_COUNTER_PRESCALE_EN
      mdv = dv;
`else
      mdv = 0;
`endif
      model_step(st, sp, os, lim, mdv);
      e.cnt  = m_cnt;
      e.tc   = m_tc;
      e.busy = (m_mode == 1);
      e.done = (m_mode == 2);
      sb.push_back(e);
   endtask

   // Monitor: outputs are valid every cycle; compare one queued entry per edge.
   exp_t me;
   always @(posedge clock) begin
      #1;
      if (sb.size() > 0) begin
         me = sb.pop_front();
         chk("count", 32'(count), me.cnt);
         chk("tc",    32'(tc),    32'(me.tc));
         chk("busy",  32'(busy),  32'(me.busy));
         chk("done",  32'(done),  32'(me.done));
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #2;
      chk("rst_count", 32'(count), 0);
      chk("rst_tc",    32'(tc),    0);
      chk("rst_busy",  32'(busy),  0);
      chk("rst_done",  32'(done),  0);
      @(negedge clock);
      reset = 1'b0;

      // start and stop together in IDLE: stays idle
      cycle(1, 1, 0, 5, 0);
      cycle(1, 1, 0, 5, 0);
      cycle(0, 0, 0, 5, 0);

      // free-run limit 5, then limit changed to 2 mid-run
      cycle(1, 0, 0, 5, 0);
      repeat (8) cycle(0, 0, 0, 5, 0);
      repeat (8) cycle(0, 0, 1, 2, 0);
      cycle(0, 1, 0, 5, 0);

      // stop at count 2
      cycle(1, 0, 0, 5, 0);
      repeat (2) cycle(0, 0, 0, 5, 0);
      cycle(0, 1, 0, 5, 0);
      cycle(0, 0, 0, 5, 0);

      // one-shot limit 3, hold, then relaunch; start ignored while running
      cycle(1, 0, 1, 3, 0);
      repeat (3) cycle(1, 0, 0, 7, 0);
      repeat (4) cycle(0, 0, 0, 3, 0);
      cycle(1, 0, 1, 3, 0);
      repeat (2) cycle(0, 0, 0, 3, 0);
      cycle(0, 1, 0, 3, 0);

      // limit all-ones free-run wraps 15 -> 0
      cycle(1, 0, 0, 15, 0);
      repeat (20) cycle(0, 0, 0, 15, 0);
      cycle(0, 1, 0, 15, 0);

      // limit 0, free-run and one-shot
      cycle(1, 0, 0, 0, 0);
      repeat (4) cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(1, 0, 1, 0, 0);
      repeat (3) cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);

      // prescaled run (divisor honoured only when the feature is built in)
      cycle(1, 0, 0, 2, 2);
      repeat (20) cycle(0, 0, 0, 2, 2);
      cycle(0, 1, 0, 2, 2);

      // asynchronous reset mid-count: limit 9, count 5
      cycle(1, 0, 0, 9, 0);
      repeat (5) cycle(0, 0, 0, 9, 0);
      @(negedge clock);
      start = 1'b0; stop = 1'b0;
      #2;
      chk("pre_rst_count", 32'(count), 5);
      reset = 1'b1;
      #1;
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_busy",  32'(busy),  0);
      chk("async_rst_tc",    32'(tc),    0);
      @(negedge clock);
      reset = 1'b0;
      model_reset();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clock);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule : tb_modulo_up_counter
